step_decoder: RTL and testbench

//   Parametrised sequential decoder: an internal SEL_W-bit step counter drives a
//   one-hot decoder of 2**SEL_W outputs. Generates control-step timing signals
//   T0..T(LAST) for the control unit, and replaces ad-hoc counter+DecoderNtoM pairs.

---
 rtl/step_decoder_pkg.sv | 41 ++++
 rtl/decoder_n.sv | 18 +
 rtl/step_decoder.sv | 106 ++++++++++
 tb/tb_step_decoder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/step_decoder_pkg.sv
// Shared definitions for the step decoder: one-hot width macro, legal
// counter-width range and the per-edge action encoding.

`ifndef DECODER_DEFS_DONE
`define DECODER_DEFS_DONE
// One-hot output width for an n-bit select.
`define DEC_W(n) (1<<(n))
`endif

package step_decoder_pkg;

  // Legal range of the select/counter width.
  localparam int SEL_W_MIN = 1;
  localparam int SEL_W_MAX = 5;

  // The single action taken on a clock edge.
  typedef enum logic [1:0] {
    ACT_HOLD = 2'd0,
    ACT_CLR  = 2'd1,
    ACT_LOAD = 2'd2,
    ACT_STEP = 2'd3
  } step_act_e;

  // Resolve the control inputs into one action: clr beats load beats en.
  function automatic step_act_e pick_action(input logic clr,
                                            input logic load,
                                            input logic en);
    step_act_e act;
    if (clr) begin
      act = ACT_CLR;
    end else if (load) begin
      act = ACT_LOAD;
    end else if (en) begin
      act = ACT_STEP;
    end else begin
      act = ACT_HOLD;
    end
    return act;
  endfunction

endpackage

// File: rtl/decoder_n.sv
// Combinational N-to-2**N one-hot decoder with a positive enable.
// Every output is low while en is low.

module decoder_n
  import step_decoder_pkg::*;
#(
  parameter int SEL_W = 3
) (
  output logic [`DEC_W(SEL_W)-1:0] m,
  input  logic [SEL_W-1:0]         S,
  input  logic                     en
);

  for (genvar i = 0; i < `DEC_W(SEL_W); i++) begin : g_line
    assign m[i] = (S == SEL_W'(i)) & en;
  end

endmodule

// File: rtl/step_decoder.sv
// Step counter feeding a one-hot decoder. Produces control-step timing
// lines T0..T(LAST) with load, clear, up/down stepping, a wrap pulse and
// a clamp-error pulse. The one-hot output follows sel combinationally.

module step_decoder
  import step_decoder_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int LAST  = (1 << SEL_W) - 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     load,
  input  logic [SEL_W-1:0]         load_val,
  input  logic                     en,
  input  logic                     up,
  input  logic                     oe,
  output logic [SEL_W-1:0]         sel,
  output logic [`DEC_W(SEL_W)-1:0] m,
  output logic                     wrap,
  output logic                     err
);

  // Reject parameter sets the counter cannot represent.
  if (SEL_W < SEL_W_MIN || SEL_W > SEL_W_MAX ||
      LAST < 0 || LAST > `DEC_W(SEL_W) - 1) begin : g_param_check
    $error("step_decoder: illegal parameters SEL_W=%0d LAST=%0d", SEL_W, LAST);
  end

  localparam logic [SEL_W-1:0] LAST_V = SEL_W'(LAST);
  localparam logic [SEL_W-1:0] ZERO_V = {SEL_W{1'b0}};
  localparam logic [SEL_W-1:0] ONE_V  = SEL_W'(1);

  step_act_e        act;
  logic [SEL_W-1:0] sel_next;
  logic             wrap_next;
  logic             err_next;

  // Next step and status pulses; the terminal compare happens before the
  // increment/decrement so sel never leaves 0..LAST.
  always_comb begin
    sel_next  = sel;
    wrap_next = 1'b0;
    err_next  = 1'b0;
    act       = pick_action(clr, load, en);
    case (act)
      ACT_CLR: begin
        sel_next = ZERO_V;
      end
      ACT_LOAD: begin
        if (load_val > LAST_V) begin
          sel_next = LAST_V;
          err_next = 1'b1;
        end else begin
          sel_next = load_val;
        end
      end
      ACT_STEP: begin
        if (up) begin
          if (sel == LAST_V) begin
            sel_next  = ZERO_V;
            wrap_next = 1'b1;
          end else begin
            sel_next = sel + ONE_V;
          end
        end else begin
          if (sel == ZERO_V) begin
            sel_next  = LAST_V;
            wrap_next = 1'b1;
          end else begin
            sel_next = sel - ONE_V;
          end
        end
      end
      ACT_HOLD: begin
        sel_next = sel;
      end
      default: begin
        sel_next = ZERO_V;
      end
    endcase
  end

  // Step register and single-cycle wrap/err pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel  <= ZERO_V;
      wrap <= 1'b0;
      err  <= 1'b0;
    end else begin
      sel  <= sel_next;
      wrap <= wrap_next;
      err  <= err_next;
    end
  end

  decoder_n #(
    .SEL_W (SEL_W)
  ) u_dec (
    .m  (m),
    .S  (sel),
    .en (oe)
  );

endmodule

// File: tb/tb_step_decoder.sv
// Directed bench for step_decoder. Several parameterisations share one set
// of control inputs; each test checks the instance it targets.

module tb_step_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr, load, en, up, oe;
  logic [2:0] lv3;
  logic [4:0] lv5;

  logic [2:0]  sel7, sel5, sel0;
  logic [7:0]  m7, m5, m0;
  logic        wrap7, wrap5, wrap0, err7, err5, err0;
  logic [4:0]  sel31;
  logic [31:0] m31;
  logic        wrap31, err31;
  logic [0:0]  sel1;
  logic [1:0]  m1;
  logic        wrap1, err1;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  step_decoder #(.SEL_W(3), .LAST(7)) d7 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(lv3), .en(en),
    .up(up), .oe(oe), .sel(sel7), .m(m7), .wrap(wrap7), .err(err7));
  step_decoder #(.SEL_W(3), .LAST(5)) d5 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(lv3), .en(en),
    .up(up), .oe(oe), .sel(sel5), .m(m5), .wrap(wrap5), .err(err5));
  step_decoder #(.SEL_W(3), .LAST(0)) d0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(lv3), .en(en),
    .up(up), .oe(oe), .sel(sel0), .m(m0), .wrap(wrap0), .err(err0));
  step_decoder #(.SEL_W(5), .LAST(31)) d31 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(lv5), .en(en),
    .up(up), .oe(oe), .sel(sel31), .m(m31), .wrap(wrap31), .err(err31));
  step_decoder #(.SEL_W(1), .LAST(1)) d1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(lv3[0:0]), .en(en),
    .up(up), .oe(oe), .sel(sel1), .m(m1), .wrap(wrap1), .err(err1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; oe = 1'b1;
    lv3 = 3'd0; lv5 = 5'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int          e;
  logic [7:0]  em8;
  logic [31:0] em32;
  int          t2 [7] = '{5, 4, 3, 2, 1, 0, 5};
  int          t1s [3] = '{1, 0, 1};

  initial begin
    // Reset state of every instance
    do_reset();
    check("rst_sel7", 32'(sel7), 32'd0);   check("rst_m7", 32'(m7), 32'h01);
    check("rst_wrap7", 32'(wrap7), 32'd0); check("rst_err7", 32'(err7), 32'd0);
    check("rst_m5", 32'(m5), 32'h01);      check("rst_m0", 32'(m0), 32'h01);
    check("rst_m31", m31, 32'h1);          check("rst_m1", 32'(m1), 32'h1);
    check("rst_flags", 32'({wrap5, err5, wrap0, err0, wrap31, err31, wrap1, err1}), 32'd0);

    // 1: full up count on LAST=7
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      e = (i + 1) % 8;
      em8 = 8'd1 << e;
      check($sformatf("t1_sel[%0d]", i), 32'(sel7), 32'(e));
      check($sformatf("t1_m[%0d]", i), 32'(m7), 32'(em8));
      check($sformatf("t1_wrap[%0d]", i), 32'(wrap7), 32'(e == 0));
    end

    // 2: down count on LAST=5 from 0
    do_reset();
    en = 1'b1; up = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      em8 = 8'd1 << t2[i];
      check($sformatf("t2_sel[%0d]", i), 32'(sel5), 32'(t2[i]));
      check($sformatf("t2_m[%0d]", i), 32'(m5), 32'(em8));
      check($sformatf("t2_hi[%0d]", i), 32'(m5[7:6]), 32'd0);
      check($sformatf("t2_wrap[%0d]", i), 32'(wrap5), 32'(i == 0 || i == 6));
    end

    // 3: clamped load, legal load, hold
    do_reset();
    load = 1'b1; lv3 = 3'd7;
    tick();
    check("t3_sel5_clamp", 32'(sel5), 32'd5); check("t3_err5", 32'(err5), 32'd1);
    check("t3_sel7_load", 32'(sel7), 32'd7);  check("t3_err7", 32'(err7), 32'd0);
    check("t3_sel0_clamp", 32'(sel0), 32'd0); check("t3_err0", 32'(err0), 32'd1);
    lv3 = 3'd3;
    tick();
    check("t3_sel5_ok", 32'(sel5), 32'd3);    check("t3_err5_clr", 32'(err5), 32'd0);
    lv3 = 3'd6;
    tick();
    check("t3_sel5_c6", 32'(sel5), 32'd5);    check("t3_err5_c6", 32'(err5), 32'd1);
    load = 1'b0;
    tick();
    check("t3_hold_sel", 32'(sel5), 32'd5);   check("t3_hold_err", 32'(err5), 32'd0);
    check("t3_hold_wrap", 32'(wrap5), 32'd0);

    // 4: priority clr > load > en, from sel5 = LAST
    clr = 1'b1; load = 1'b1; lv3 = 3'd7; en = 1'b1; up = 1'b1;
    tick();
    check("t4_clr_sel", 32'(sel5), 32'd0);    check("t4_clr_wrap", 32'(wrap5), 32'd0);
    check("t4_clr_err", 32'(err5), 32'd0);
    clr = 1'b0; lv3 = 3'd2;
    tick();
    check("t4_load_sel", 32'(sel5), 32'd2);   check("t4_load_wrap", 32'(wrap5), 32'd0);
    load = 1'b0; en = 1'b0;

    // 5: async reset mid-count, then output enable
    do_reset();
    en = 1'b1; up = 1'b1;
    repeat (4) tick();
    check("t5_sel4", 32'(sel7), 32'd4);
    #3 rst_n = 1'b0;
    #1;
    check("t5_arst_sel", 32'(sel7), 32'd0);   check("t5_arst_m", 32'(m7), 32'h01);
    #1 rst_n = 1'b1;
    tick();
    check("t5_post_sel", 32'(sel7), 32'd1);
    oe = 1'b0;
    #1;
    check("t5_oe0_m", 32'(m7), 32'd0);        check("t5_oe0_sel", 32'(sel7), 32'd1);
    tick();
    check("t5_cnt_sel", 32'(sel7), 32'd2);    check("t5_cnt_m", 32'(m7), 32'd0);
    tick();
    check("t5_cnt_sel2", 32'(sel7), 32'd3);
    oe = 1'b1;
    #1;
    check("t5_oe1_m", 32'(m7), 32'h08);

    // 6a: LAST=0 wraps on every step, both directions
    do_reset();
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) up = 1'b0;
      tick();
      check($sformatf("t6_sel0[%0d]", i), 32'(sel0), 32'd0);
      check($sformatf("t6_m0[%0d]", i), 32'(m0), 32'h01);
      check($sformatf("t6_wrap0[%0d]", i), 32'(wrap0), 32'd1);
    end
    en = 1'b0;
    tick();
    check("t6_wrap0_idle", 32'(wrap0), 32'd0);

    // 6b: SEL_W=5 full sweep
    do_reset();
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      e = (i + 1) % 32;
      em32 = 32'd1 << e;
      check($sformatf("t6_sel31[%0d]", i), 32'(sel31), 32'(e));
      check($sformatf("t6_m31[%0d]", i), m31, em32);
      check($sformatf("t6_top[%0d]", i), 32'(m31[31]), 32'(e == 31));
      check($sformatf("t6_wrap31[%0d]", i), 32'(wrap31), 32'(e == 0));
    end

    // 6c: SEL_W=1 toggles as a 1-to-2 decoder
    do_reset();
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t6_sel1[%0d]", i), 32'(sel1), 32'(t1s[i]));
      check($sformatf("t6_m1[%0d]", i), 32'(m1), 32'(t1s[i] == 1 ? 2 : 1));
      check($sformatf("t6_wrap1[%0d]", i), 32'(wrap1), 32'(t1s[i] == 0));
    end
    en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
